// File: rtl/mem_sys_pkg.sv
// Shared types and helpers for the cached DRAM memory system request front-end.
package mem_sys_pkg;

  localparam int WORD_W      = 16;
  localparam int DEF_PHASE_W = 2;

  typedef logic [WORD_W-1:0]      word_t;
  typedef logic [DEF_PHASE_W-1:0] phase_t;

  // Attributes carried unchanged from the granted producer into the issue register.
  typedef struct packed {
    logic [2:0] len;
    logic       is_byte;
    logic       is_write;
  } req_attr_t;

  // Index width that never collapses to zero, so single-entry arrays still get a 1-bit select.
  function automatic int clog2_min1(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

  // The move code meaning "leave the words where they are" is always the largest word index.
  function automatic int move_none(input int words);
    return words - 1;
  endfunction

endpackage

// File: rtl/mem_req_rotate.sv
// Combinational word shifter: moves words down by (move+1) positions, zero-filling the top,
// or passes them through untouched when the move code is the "no shift" value.
module mem_req_rotate
  import mem_sys_pkg::*;
#(
  parameter  int WORDS  = 4,
  localparam int MOVE_W = clog2_min1(WORDS)
) (
  input  word_t [WORDS-1:0] in_words,
  input  logic  [MOVE_W-1:0] move,
  output word_t [WORDS-1:0] out_words
);

  int src_idx;

  // Pick each output word from in_words[i+move+1], or zero when that runs off the top.
  always_comb begin
    out_words = '0;
    src_idx   = 0;
    if (int'(move) >= move_none(WORDS)) begin
      out_words = in_words;
    end else begin
      for (int i = 0; i < WORDS; i++) begin
        src_idx = i + int'(move) + 1;
        if (src_idx < WORDS) begin
          out_words[MOVE_W'(i)] = in_words[MOVE_W'(src_idx)];
        end
      end
    end
  end

endmodule

// File: rtl/mem_request_arbiter.sv
// Multi-channel request front-end: per-channel phase handshakes, round-robin grant,
// request normalisation and a single issue register that holds while the cache faults.
module mem_request_arbiter
  import mem_sys_pkg::*;
#(
  parameter  int CHANNELS   = 2,
  parameter  int ADDR_W     = 31,
  parameter  int WORDS      = 4,
  parameter  int LINE_BYTES = 16,
  parameter  int PHASE_W    = 2,
  localparam int CH_W       = clog2_min1(CHANNELS),
  localparam int MOVE_W     = clog2_min1(WORDS)
) (
  input  logic                                 main_clk,
  input  logic                                 main_rst_n,
  input  logic  [CHANNELS-1:0][PHASE_W-1:0]    req_phase,
  input  logic  [CHANNELS-1:0][ADDR_W-1:0]     req_address,
  input  word_t [CHANNELS-1:0][WORDS-1:0]      req_data,
  input  logic  [CHANNELS-1:0][MOVE_W-1:0]     req_move,
  input  logic  [CHANNELS-1:0]                 req_secondary,
  input  logic  [CHANNELS-1:0][2:0]            req_len,
  input  logic  [CHANNELS-1:0]                 req_byte,
  input  logic  [CHANNELS-1:0]                 req_write,
  input  logic                                 fault_stall,
  output logic  [CHANNELS-1:0][PHASE_W-1:0]    ack_phase1,
  output logic  [CHANNELS-1:0][PHASE_W-1:0]    done_phase2,
  output logic  [CHANNELS-1:0]                 done_moved,
  output logic                                 iss_valid,
  output logic  [CH_W-1:0]                     iss_channel,
  output logic  [ADDR_W-1:0]                   iss_address,
  output word_t [WORDS-1:0]                    iss_data,
  output logic  [2:0]                          iss_len,
  output logic                                 iss_byte,
  output logic                                 iss_write
);

  // Registered state
  logic [CHANNELS-1:0][PHASE_W-1:0] ack_phase1_q, ack_phase1_d;
  logic [CHANNELS-1:0][PHASE_W-1:0] done_phase2_q, done_phase2_d;
  logic [CHANNELS-1:0]              done_moved_q, done_moved_d;
  logic [CH_W-1:0]                  ptr_q, ptr_d;
  logic                             iss_valid_q, iss_valid_d;
  logic [CH_W-1:0]                  iss_channel_q, iss_channel_d;
  logic [ADDR_W-1:0]                iss_address_q, iss_address_d;
  word_t [WORDS-1:0]                iss_data_q, iss_data_d;
  req_attr_t                        iss_attr_q, iss_attr_d;

  // Grant and request-path signals
  logic [CHANNELS-1:0] pending;
  logic                grant_found;
  logic [CH_W-1:0]     grant_idx;
  int                  scan_idx;
  logic [ADDR_W-1:0]   sel_address;
  logic [ADDR_W-1:0]   bumped_address;
  logic [ADDR_W-1:0]   norm_address;
  word_t [WORDS-1:0]   sel_data;
  word_t [WORDS-1:0]   rot_data;
  logic [MOVE_W-1:0]   sel_move;
  logic                sel_secondary;
  req_attr_t           sel_attr;

  // A channel has work whenever its producer phase has run ahead of what we last accepted.
  always_comb begin
    pending = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      pending[CH_W'(c)] = (req_phase[CH_W'(c)] != ack_phase1_q[CH_W'(c)]);
    end
  end

  // Round-robin search: first pending channel starting at the pointer, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      scan_idx = (int'(ptr_q) + k) % CHANNELS;
      if (!grant_found && pending[CH_W'(scan_idx)]) begin
        grant_found = 1'b1;
        grant_idx   = CH_W'(scan_idx);
      end
    end
  end

  // Steer the winning channel's request fields into the shared normalisation path.
  always_comb begin
    sel_address   = req_address[grant_idx];
    sel_data      = req_data[grant_idx];
    sel_move      = req_move[grant_idx];
    sel_secondary = req_secondary[grant_idx];
    sel_attr      = '{len: req_len[grant_idx], is_byte: req_byte[grant_idx], is_write: req_write[grant_idx]};
  end

  // Secondary-line requests point at the start of the following cache line, wrapping at the top.
  always_comb begin
    bumped_address = sel_address + ADDR_W'(LINE_BYTES);
    norm_address   = sel_address;
    if (sel_secondary) begin
      norm_address = bumped_address & ~ADDR_W'(LINE_BYTES - 1);
    end
  end

  mem_req_rotate #(
    .WORDS(WORDS)
  ) u_rotate (
    .in_words (sel_data),
    .move     (sel_move),
    .out_words(rot_data)
  );

  // Next state: a fault freezes everything; otherwise phases advance and the issue register
  // either takes the granted request or drops to idle with its fields left as they were.
  always_comb begin
    ack_phase1_d  = ack_phase1_q;
    done_phase2_d = done_phase2_q;
    done_moved_d  = '0;
    ptr_d         = ptr_q;
    iss_valid_d   = iss_valid_q;
    iss_channel_d = iss_channel_q;
    iss_address_d = iss_address_q;
    iss_data_d    = iss_data_q;
    iss_attr_d    = iss_attr_q;

    if (!fault_stall) begin
      for (int c = 0; c < CHANNELS; c++) begin
        done_moved_d[CH_W'(c)] = (done_phase2_q[CH_W'(c)] != ack_phase1_q[CH_W'(c)]);
      end
      done_phase2_d = ack_phase1_q;

      if (grant_found) begin
        ack_phase1_d[grant_idx] = ack_phase1_q[grant_idx] + PHASE_W'(1);
        iss_valid_d             = 1'b1;
        iss_channel_d           = grant_idx;
        iss_address_d           = norm_address;
        iss_data_d              = rot_data;
        iss_attr_d              = sel_attr;
        ptr_d                   = (int'(grant_idx) == CHANNELS - 1) ? '0 : grant_idx + CH_W'(1);
      end else begin
        iss_valid_d = 1'b0;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      ack_phase1_q  <= '0;
      done_phase2_q <= '0;
      done_moved_q  <= '0;
      ptr_q         <= '0;
      iss_valid_q   <= 1'b0;
      iss_channel_q <= '0;
      iss_address_q <= '0;
      iss_data_q    <= '0;
      iss_attr_q    <= '0;
    end else begin
      ack_phase1_q  <= ack_phase1_d;
      done_phase2_q <= done_phase2_d;
      done_moved_q  <= done_moved_d;
      ptr_q         <= ptr_d;
      iss_valid_q   <= iss_valid_d;
      iss_channel_q <= iss_channel_d;
      iss_address_q <= iss_address_d;
      iss_data_q    <= iss_data_d;
      iss_attr_q    <= iss_attr_d;
    end
  end

  assign ack_phase1  = ack_phase1_q;
  assign done_phase2 = done_phase2_q;
  assign done_moved  = done_moved_q;
  assign iss_valid   = iss_valid_q;
  assign iss_channel = iss_channel_q;
  assign iss_address = iss_address_q;
  assign iss_data    = iss_data_q;
  assign iss_len     = iss_attr_q.len;
  assign iss_byte    = iss_attr_q.is_byte;
  assign iss_write   = iss_attr_q.is_write;

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Self-checking bench for mem_request_arbiter: directed scenarios with literal expectations,
// then randomized producers, stalls and resets checked every cycle against a behavioural model.
module tb_mem_request_arbiter;

  localparam int CHANNELS   = 2;
  localparam int ADDR_W     = 31;
  localparam int WORDS      = 4;
  localparam int LINE_BYTES = 16;
  localparam int PHASE_W    = 2;
  localparam int CH_W       = 1;
  localparam int MOVE_W     = 2;
  localparam int PHASE_MOD  = 1 << PHASE_W;
  localparam longint ADDR_MOD = 64'd1 << ADDR_W;

  logic main_clk = 1'b0;
  logic main_rst_n = 1'b0;
  logic [CHANNELS-1:0][PHASE_W-1:0]    req_phase;
  logic [CHANNELS-1:0][ADDR_W-1:0]     req_address;
  logic [CHANNELS-1:0][WORDS-1:0][15:0] req_data;
  logic [CHANNELS-1:0][MOVE_W-1:0]     req_move;
  logic [CHANNELS-1:0]                 req_secondary;
  logic [CHANNELS-1:0][2:0]            req_len;
  logic [CHANNELS-1:0]                 req_byte;
  logic [CHANNELS-1:0]                 req_write;
  logic                                fault_stall;
  logic [CHANNELS-1:0][PHASE_W-1:0]    ack_phase1;
  logic [CHANNELS-1:0][PHASE_W-1:0]    done_phase2;
  logic [CHANNELS-1:0]                 done_moved;
  logic                                iss_valid;
  logic [CH_W-1:0]                     iss_channel;
  logic [ADDR_W-1:0]                   iss_address;
  logic [WORDS-1:0][15:0]              iss_data;
  logic [2:0]                          iss_len;
  logic                                iss_byte;
  logic                                iss_write;

  mem_request_arbiter #(
    .CHANNELS(CHANNELS), .ADDR_W(ADDR_W), .WORDS(WORDS), .LINE_BYTES(LINE_BYTES), .PHASE_W(PHASE_W)
  ) dut (
    .main_clk(main_clk), .main_rst_n(main_rst_n),
    .req_phase(req_phase), .req_address(req_address), .req_data(req_data), .req_move(req_move),
    .req_secondary(req_secondary), .req_len(req_len), .req_byte(req_byte), .req_write(req_write),
    .fault_stall(fault_stall),
    .ack_phase1(ack_phase1), .done_phase2(done_phase2), .done_moved(done_moved),
    .iss_valid(iss_valid), .iss_channel(iss_channel), .iss_address(iss_address), .iss_data(iss_data),
    .iss_len(iss_len), .iss_byte(iss_byte), .iss_write(iss_write)
  );

  always #5 main_clk = ~main_clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  int          m_ack [CHANNELS];
  int          m_done [CHANNELS];
  bit          m_moved [CHANNELS];
  int          m_ptr;
  bit          m_valid;
  int          m_ch;
  longint      m_addr;
  logic [63:0] m_data;
  int          m_len;
  bit          m_byte;
  bit          m_write;

  int prod [CHANNELS];

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Secondary: start of the following line, modulo the address space.
  function automatic longint expected_address(input longint addr, input bit secondary);
    if (!secondary) return addr;
    return (((addr / LINE_BYTES) + 1) * LINE_BYTES) % ADDR_MOD;
  endfunction

  function automatic logic [63:0] expected_data(input logic [63:0] words_in, input int move);
    logic [63:0] r;
    r = '0;
    if (move == WORDS - 1) return words_in;
    for (int i = 0; i < WORDS; i++) begin
      if (i + move + 1 < WORDS) r[i*16 +: 16] = words_in[(i+move+1)*16 +: 16];
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < CHANNELS; c++) begin
      m_ack[c] = 0; m_done[c] = 0; m_moved[c] = 1'b0;
    end
    m_ptr = 0; m_valid = 1'b0; m_ch = 0; m_addr = 0; m_data = '0;
    m_len = 0; m_byte = 1'b0; m_write = 1'b0;
  endtask

  task automatic model_step();
    int  g;
    bit  found;
    if (fault_stall) begin
      for (int c = 0; c < CHANNELS; c++) m_moved[c] = 1'b0;
      return;
    end
    for (int c = 0; c < CHANNELS; c++) begin
      m_moved[c] = (m_done[c] != m_ack[c]);
      m_done[c]  = m_ack[c];
    end
    found = 1'b0;
    g = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      int c;
      c = (m_ptr + k) % CHANNELS;
      if (!found && int'(req_phase[CH_W'(c)]) != m_ack[c]) begin
        found = 1'b1;
        g = c;
      end
    end
    if (found) begin
      m_ack[g] = (m_ack[g] + 1) % PHASE_MOD;
      m_valid  = 1'b1;
      m_ch     = g;
      m_ptr    = (g + 1) % CHANNELS;
      m_addr   = expected_address(longint'(req_address[CH_W'(g)]), req_secondary[CH_W'(g)]);
      m_data   = expected_data(req_data[CH_W'(g)], int'(req_move[CH_W'(g)]));
      m_len    = int'(req_len[CH_W'(g)]);
      m_byte   = req_byte[CH_W'(g)];
      m_write  = req_write[CH_W'(g)];
    end else begin
      m_valid = 1'b0;
    end
  endtask

  function automatic logic [63:0] pack_phases(input int p0, input int p1);
    logic [63:0] v;
    v = '0;
    v[PHASE_W-1:0]         = PHASE_W'(p0);
    v[2*PHASE_W-1:PHASE_W] = PHASE_W'(p1);
    return v;
  endfunction

  // Model advances on the same edges as the DUT and clears on reset assertion.
  always @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) model_clear();
    else model_step();
  end

  // Every cycle, shortly after the edge, compare all DUT outputs with the model.
  always @(posedge main_clk) begin
    #2;
    check_output("ack_phase1", 64'(ack_phase1), pack_phases(m_ack[0], m_ack[1]));
    check_output("done_phase2", 64'(done_phase2), pack_phases(m_done[0], m_done[1]));
    check_output("done_moved", 64'(done_moved), {62'b0, m_moved[1], m_moved[0]});
    check_output("iss_valid", 64'(iss_valid), 64'(m_valid));
    check_output("iss_channel", 64'(iss_channel), 64'(m_ch));
    check_output("iss_address", 64'(iss_address), 64'(m_addr));
    check_output("iss_data", 64'(iss_data), m_data);
    check_output("iss_len", 64'(iss_len), 64'(m_len));
    check_output("iss_byte", 64'(iss_byte), 64'(m_byte));
    check_output("iss_write", 64'(iss_write), 64'(m_write));
  end

  task automatic clear_inputs();
    req_phase = '0; req_address = '0; req_data = '0; req_move = '1;
    req_secondary = '0; req_len = '0; req_byte = '0; req_write = '0; fault_stall = 1'b0;
    for (int c = 0; c < CHANNELS; c++) prod[c] = 0;
  endtask

  task automatic do_reset();
    @(negedge main_clk);
    main_rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge main_clk);
    main_rst_n = 1'b1;
  endtask

  task automatic post(input int c);
    prod[c] = (prod[c] + 1) % PHASE_MOD;
    req_phase[CH_W'(c)] = PHASE_W'(prod[c]);
  endtask

  task automatic apply_stimulus(input int c, input logic [ADDR_W-1:0] addr, input bit sec,
                                input logic [63:0] data, input logic [MOVE_W-1:0] mv);
    req_address[CH_W'(c)]   = addr;
    req_secondary[CH_W'(c)] = sec;
    req_data[CH_W'(c)]      = data;
    req_move[CH_W'(c)]      = mv;
    post(c);
  endtask

  initial begin
    int exp_ack [5];
    int exp_done [5];
    exp_ack  = '{1, 2, 3, 0, 1};
    exp_done = '{0, 1, 2, 3, 0};

    clear_inputs();
    repeat (3) @(negedge main_clk);
    main_rst_n = 1'b1;

    $display("[TB] reset idle");
    repeat (10) begin
      @(negedge main_clk);
      check_output("idle_valid", 64'(iss_valid), 64'd0);
      check_output("idle_ack", 64'(ack_phase1), 64'd0);
      check_output("idle_done", 64'(done_phase2), 64'd0);
      check_output("idle_moved", 64'(done_moved), 64'd0);
    end

    $display("[TB] simultaneous posts and round robin");
    do_reset();
    post(0); post(1);
    @(negedge main_clk);
    check_output("rr_first_ch", 64'(iss_channel), 64'd0);
    check_output("rr_first_valid", 64'(iss_valid), 64'd1);
    check_output("rr_first_ack", 64'(ack_phase1), 64'h1);
    @(negedge main_clk);
    check_output("rr_second_ch", 64'(iss_channel), 64'd1);
    check_output("rr_second_ack", 64'(ack_phase1), 64'h5);
    check_output("rr_second_done", 64'(done_phase2), 64'h1);
    check_output("rr_second_moved", 64'(done_moved), 64'h1);
    post(0); post(1);
    @(negedge main_clk);
    check_output("rr_again_ch0", 64'(iss_channel), 64'd0);
    @(negedge main_clk);
    check_output("rr_again_ch1", 64'(iss_channel), 64'd1);
    @(negedge main_clk);
    check_output("rr_idle_valid", 64'(iss_valid), 64'd0);
    check_output("rr_idle_hold_ch", 64'(iss_channel), 64'd1);

    $display("[TB] address and data normalisation");
    apply_stimulus(0, 31'h0000_0123, 1'b1, 64'h0004_0003_0002_0001, 2'd3);
    @(negedge main_clk);
    check_output("addr_bump", 64'(iss_address), 64'h130);
    check_output("model_addr_bump", 64'(m_addr), 64'h130);
    apply_stimulus(0, 31'h7FFF_FFF5, 1'b1, 64'h0004_0003_0002_0001, 2'd3);
    @(negedge main_clk);
    check_output("addr_wrap", 64'(iss_address), 64'h0);
    check_output("data_passthru", 64'(iss_data), 64'h0004_0003_0002_0001);
    apply_stimulus(0, 31'h0000_0040, 1'b0, 64'h0004_0003_0002_0001, 2'd0);
    @(negedge main_clk);
    check_output("addr_plain", 64'(iss_address), 64'h40);
    check_output("data_move0", 64'(iss_data), 64'h0000_0004_0003_0002);
    check_output("model_data_move0", m_data, 64'h0000_0004_0003_0002);
    apply_stimulus(0, 31'h0000_0040, 1'b0, 64'h0004_0003_0002_0001, 2'd1);
    @(negedge main_clk);
    check_output("data_move1", 64'(iss_data), 64'h0000_0000_0004_0003);

    $display("[TB] fault stall hold and replay");
    do_reset();
    req_len[0] = 3'd5;
    apply_stimulus(0, 31'h0000_1000, 1'b0, 64'h1111_2222_3333_4444, 2'd3);
    @(negedge main_clk);
    check_output("stall_pre_ch", 64'(iss_channel), 64'd0);
    fault_stall = 1'b1;
    for (int s = 0; s < 5; s++) begin
      if (s == 2) post(1);
      @(negedge main_clk);
      check_output("stall_valid", 64'(iss_valid), 64'd1);
      check_output("stall_ch", 64'(iss_channel), 64'd0);
      check_output("stall_addr", 64'(iss_address), 64'h1000);
      check_output("stall_len", 64'(iss_len), 64'd5);
      check_output("stall_ack", 64'(ack_phase1), 64'h1);
      check_output("stall_done", 64'(done_phase2), 64'h0);
      check_output("stall_moved", 64'(done_moved), 64'h0);
    end
    fault_stall = 1'b0;
    @(negedge main_clk);
    check_output("unstall_ch", 64'(iss_channel), 64'd1);
    check_output("unstall_ack", 64'(ack_phase1), 64'h5);
    check_output("unstall_moved", 64'(done_moved), 64'h1);

    $display("[TB] phase wrap");
    do_reset();
    for (int i = 0; i < 5; i++) begin
      post(0);
      @(negedge main_clk);
      check_output("wrap_ack0", 64'(ack_phase1[0]), 64'(exp_ack[i]));
      check_output("wrap_done0", 64'(done_phase2[0]), 64'(exp_done[i]));
    end

    $display("[TB] randomized traffic");
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge main_clk);
      if (!main_rst_n) main_rst_n = 1'b1;
      else if ($urandom_range(0, 199) == 0) main_rst_n = 1'b0;
      fault_stall = ($urandom_range(0, 5) == 0);
      for (int c = 0; c < CHANNELS; c++) begin
        if ($urandom_range(0, 2) == 0 && ((prod[c] - m_ack[c] + PHASE_MOD) % PHASE_MOD) < PHASE_MOD - 1) begin
          req_address[CH_W'(c)]   = ADDR_W'($urandom);
          req_data[CH_W'(c)]      = {$urandom, $urandom};
          req_move[CH_W'(c)]      = MOVE_W'($urandom_range(0, 3));
          req_secondary[CH_W'(c)] = 1'($urandom_range(0, 1));
          req_len[CH_W'(c)]       = 3'($urandom_range(0, 7));
          req_byte[CH_W'(c)]      = 1'($urandom_range(0, 1));
          req_write[CH_W'(c)]     = 1'($urandom_range(0, 1));
          post(c);
        end
      end
    end
    main_rst_n = 1'b1;
    fault_stall = 1'b0;
    repeat (8) @(negedge main_clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
